input_width_transform: RTL and testbench

//  Receive-side host interface: takes the 8-bit byte stream from the PHY and strips preamble/SFD.

---
 rtl/input_width_transform_pkg.sv | 34 +++
 rtl/input_width_transform.sv | 176 +++++++++++++++++
 tb/tb_input_width_transform.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/input_width_transform_pkg.sv
// Shared constants and types for the receive-side host interface:
// word flags, preamble/SFD byte values and the framing FSM state type.
package input_width_transform_pkg;

   localparam logic [2:0] PREAMBLE_MAX  = 3'd7;
   localparam logic [3:0] MD_BYTES      = 4'd8;
   localparam logic [3:0] MD_LAST       = 4'd7;
   localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
   localparam logic [7:0] SFD_BYTE      = 8'hd5;

   localparam logic [1:0] FLAG_HEAD = 2'b01;
   localparam logic [1:0] FLAG_MID  = 2'b11;
   localparam logic [1:0] FLAG_TAIL = 2'b10;

   typedef enum logic [2:0] {
      IDLE_S     = 3'd0,
      PREAMBLE_S = 3'd1,
      MD_S       = 3'd2,
      PKT_S      = 3'd3,
      DISCARD_S  = 3'd4
   } state_t;

   // Number of unused trailing bytes in the tail word; a full word has none.
   function automatic logic [3:0] tail_invalid(input logic full, input logic [3:0] cnt);
      logic [4:0] rem;
      rem = 5'd16 - {1'b0, cnt};
      if (full) begin
         tail_invalid = 4'd0;
      end else begin
         tail_invalid = rem[3:0];
      end
   endfunction

endpackage

// File: rtl/input_width_transform.sv
// Strips preamble/SFD from the PHY byte stream and packs metadata plus frame
// bytes into 134-bit {flag, invalid, data} words for the HCP input buffer.
module input_width_transform
   import input_width_transform_pkg::*;
(
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic [7:0]   iv_data,
   input  logic         i_data_wr,
   output logic [133:0] ov_pkt_data,
   output logic         o_pkt_data_wr,
   output logic         o_frame_err
);

   state_t         state_r, state_s;
   logic [2:0]     pre_cnt_r, pre_cnt_s;
   logic [3:0]     cnt_r, cnt_s;
   logic           full_r, full_s;
   logic           is_md_r, is_md_s;
   logic [127:0]   asm_r, asm_s;
   logic [127:0]   lane_asm_s;
   logic [133:0]   pkt_data_r, pkt_data_s;
   logic           pkt_wr_r, pkt_wr_s;
   logic           frame_err_r, frame_err_s;

   // Assembly register with the current byte dropped into lane cnt_r.
   always_comb begin
      lane_asm_s = asm_r;
      for (int i = 0; i < 16; i++) begin
         if (cnt_r == 4'(i)) begin
            lane_asm_s[127-8*i -: 8] = iv_data;
         end else begin
            lane_asm_s[127-8*i -: 8] = asm_r[127-8*i -: 8];
         end
      end
   end

   // Framing FSM: next state, datapath updates and output strobes.
   always_comb begin
      state_s     = state_r;
      pre_cnt_s   = pre_cnt_r;
      cnt_s       = cnt_r;
      full_s      = full_r;
      is_md_s     = is_md_r;
      asm_s       = asm_r;
      pkt_data_s  = pkt_data_r;
      pkt_wr_s    = 1'b0;
      frame_err_s = 1'b0;

      case (state_r)
         IDLE_S: begin
            if (i_data_wr) begin
               if (iv_data == PREAMBLE_BYTE) begin
                  state_s   = PREAMBLE_S;
                  pre_cnt_s = 3'd1;
               end else begin
                  state_s     = DISCARD_S;
                  frame_err_s = 1'b1;
               end
            end else begin
               state_s = IDLE_S;
            end
         end

         PREAMBLE_S: begin
            if (!i_data_wr) begin
               state_s     = IDLE_S;
               frame_err_s = 1'b1;
            end else if (iv_data == SFD_BYTE) begin
               state_s = MD_S;
               asm_s   = 128'd0;
               cnt_s   = 4'd0;
               full_s  = 1'b0;
               is_md_s = 1'b0;
            end else if ((iv_data == PREAMBLE_BYTE) && (pre_cnt_r < PREAMBLE_MAX)) begin
               pre_cnt_s = pre_cnt_r + 3'd1;
            end else begin
               state_s     = DISCARD_S;
               frame_err_s = 1'b1;
            end
         end

         MD_S: begin
            if (i_data_wr) begin
               asm_s = lane_asm_s;
               if (cnt_r == MD_LAST) begin
                  state_s = PKT_S;
                  cnt_s   = 4'd0;
                  full_s  = 1'b1;
                  is_md_s = 1'b1;
               end else begin
                  cnt_s = cnt_r + 4'd1;
               end
            end else begin
               state_s     = IDLE_S;
               frame_err_s = 1'b1;
            end
         end

         PKT_S: begin
            if (i_data_wr) begin
               if (full_r) begin
                  // The arriving byte proves the held word complete: emit it, start a new one.
                  pkt_wr_s   = 1'b1;
                  pkt_data_s = {(is_md_r ? FLAG_HEAD : FLAG_MID), 4'h0, asm_r};
                  asm_s      = {iv_data, 120'd0};
                  cnt_s      = 4'd1;
                  full_s     = 1'b0;
                  is_md_s    = 1'b0;
               end else begin
                  asm_s  = lane_asm_s;
                  cnt_s  = cnt_r + 4'd1;
                  full_s = (cnt_r == 4'd15);
               end
            end else begin
               state_s = IDLE_S;
               if (is_md_r) begin
                  frame_err_s = 1'b1;
               end else begin
                  pkt_wr_s   = 1'b1;
                  pkt_data_s = {FLAG_TAIL, tail_invalid(full_r, cnt_r), asm_r};
               end
            end
         end

         DISCARD_S: begin
            if (i_data_wr) begin
               state_s = DISCARD_S;
            end else begin
               state_s = IDLE_S;
            end
         end

         default: begin
            state_s = IDLE_S;
         end
      endcase
   end

   // State register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_r <= IDLE_S;
      end else begin
         state_r <= state_s;
      end
   end

   // Counters, assembly register and registered outputs.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         pre_cnt_r   <= 3'd0;
         cnt_r       <= 4'd0;
         full_r      <= 1'b0;
         is_md_r     <= 1'b0;
         asm_r       <= 128'd0;
         pkt_data_r  <= 134'd0;
         pkt_wr_r    <= 1'b0;
         frame_err_r <= 1'b0;
      end else begin
         pre_cnt_r   <= pre_cnt_s;
         cnt_r       <= cnt_s;
         full_r      <= full_s;
         is_md_r     <= is_md_s;
         asm_r       <= asm_s;
         pkt_data_r  <= pkt_data_s;
         pkt_wr_r    <= pkt_wr_s;
         frame_err_r <= frame_err_s;
      end
   end

   assign ov_pkt_data   = pkt_data_r;
   assign o_pkt_data_wr = pkt_wr_r;
   assign o_frame_err   = frame_err_r;

endmodule

// File: tb/tb_input_width_transform.sv
// Directed bench for input_width_transform: expected words are queued as
// frames are driven and compared as the DUT writes them.
module tb_input_width_transform;

   logic         clk;
   logic         rst_n;
   logic [7:0]   data;
   logic         wr;
   logic [133:0] ov_pkt_data;
   logic         o_pkt_data_wr;
   logic         o_frame_err;

   int checks   = 0;
   int failures = 0;
   int err_seen = 0;
   int err_base;

   logic [133:0] sb[$];
   logic [7:0]   md_q[$];
   logic [7:0]   pl_q[$];
   logic [7:0]   raw_q[$];

   input_width_transform dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .iv_data       (data),
      .i_data_wr     (wr),
      .ov_pkt_data   (ov_pkt_data),
      .o_pkt_data_wr (o_pkt_data_wr),
      .o_frame_err   (o_frame_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Scoreboard monitor: every write must match the oldest queued word.
   always @(negedge clk) begin
      logic [133:0] exp_w;
      if (o_pkt_data_wr === 1'b1) begin
         checks++;
         assert (sb.size() != 0) else begin
            failures++;
            $error("FAIL unexpected_write observed=%h expected=none", ov_pkt_data);
         end
         if (sb.size() != 0) begin
            exp_w = sb.pop_front();
            checks++;
            assert (ov_pkt_data === exp_w) else begin
               failures++;
               $error("FAIL word observed=%h expected=%h", ov_pkt_data, exp_w);
            end
         end
      end
      if (o_frame_err === 1'b1) err_seen++;
   end

   task automatic chk(input logic [133:0] obs, input logic [133:0] exp_v, input string tag);
      checks++;
      assert (obs === exp_v) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
      end
   endtask

   task automatic drive(input logic [7:0] b);
      @(posedge clk); #1;
      data = b;
      wr   = 1'b1;
   endtask

   task automatic gap(input int n);
      repeat (n) begin
         @(posedge clk); #1;
         wr   = 1'b0;
         data = 8'h00;
      end
   endtask

   task automatic send_raw(input logic [7:0] q[$]);
      foreach (q[k]) drive(q[k]);
      gap(1);
   endtask

   task automatic send_frame(input int npre, input logic [7:0] md[$], input logic [7:0] pl[$]);
      repeat (npre) drive(8'h55);
      drive(8'hd5);
      foreach (md[k]) drive(md[k]);
      foreach (pl[k]) drive(pl[k]);
      gap(1);
   endtask

   // Reference packing: head with metadata, 16-byte chunks, last chunk is the tail.
   task automatic expect_frame(input logic [7:0] md[$], input logic [7:0] pl[$]);
      logic [127:0] w;
      int n, nw, len;
      w = 128'd0;
      for (int k = 0; k < 8; k++) w[127-8*k -: 8] = md[k];
      sb.push_back({2'b01, 4'h0, w});
      n  = pl.size();
      nw = (n + 15) / 16;
      for (int c = 0; c < nw; c++) begin
         w   = 128'd0;
         len = (n - 16*c > 16) ? 16 : n - 16*c;
         for (int k = 0; k < len; k++) w[127-8*k -: 8] = pl[16*c+k];
         if (c == nw - 1) sb.push_back({2'b10, 4'(16 - len), w});
         else             sb.push_back({2'b11, 4'h0, w});
      end
   endtask

   task automatic fill(output logic [7:0] q[$], input logic [7:0] first, input int n);
      q = {};
      for (int k = 0; k < n; k++) q.push_back(first + 8'(k));
   endtask

   task automatic check_step(input string tag, input int exp_err);
      gap(4);
      chk(134'(sb.size()), 134'd0, {tag, "_drain"});
      chk(134'(err_seen - err_base), 134'(exp_err), {tag, "_errs"});
      err_base = err_seen;
   endtask

   initial begin
      rst_n = 1'b0;
      wr    = 1'b0;
      data  = 8'h00;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk(ov_pkt_data, 134'd0, "rst_data");
      chk({133'd0, o_pkt_data_wr}, 134'd0, "rst_wr");
      chk({133'd0, o_frame_err}, 134'd0, "rst_err");
      #1 rst_n = 1'b1;
      gap(2);
      err_base = err_seen;

      // 1: 32-byte payload, two full payload words
      fill(md_q, 8'h00, 8);
      fill(pl_q, 8'h10, 32);
      expect_frame(md_q, pl_q);
      send_frame(7, md_q, pl_q);
      check_step("t1", 0);

      // 2: 5-byte payload, tail invalid=11
      fill(pl_q, 8'h10, 5);
      expect_frame(md_q, pl_q);
      send_frame(7, md_q, pl_q);
      check_step("t2", 0);

      // 3: metadata only -> error one cycle after wr falls, no write
      pl_q = {};
      send_frame(1, md_q, pl_q);
      @(negedge clk);
      chk({133'd0, o_frame_err}, 134'd0, "t3_err_early");
      @(negedge clk);
      chk({133'd0, o_frame_err}, 134'd1, "t3_err_pulse");
      @(negedge clk);
      chk({133'd0, o_frame_err}, 134'd0, "t3_err_end");
      check_step("t3", 1);

      // 4: bad byte in preamble, rest ignored, then a valid frame
      raw_q = {8'h55, 8'h55, 8'haa, 8'h55, 8'hd5, 8'h00, 8'h01, 8'h02};
      send_raw(raw_q);
      check_step("t4_bad", 1);
      fill(md_q, 8'ha0, 8);
      fill(pl_q, 8'hb0, 17);
      expect_frame(md_q, pl_q);
      send_frame(3, md_q, pl_q);
      check_step("t4_good", 0);

      // 5: eight preamble bytes -> error, no write
      fill(pl_q, 8'h30, 20);
      send_frame(8, md_q, pl_q);
      check_step("t5", 1);

      // 6: back-to-back 20-byte frames, then reset in the middle of a third
      fill(md_q, 8'h00, 8);
      fill(pl_q, 8'h40, 20);
      expect_frame(md_q, pl_q);
      send_frame(7, md_q, pl_q);
      fill(md_q, 8'hc0, 8);
      fill(pl_q, 8'h60, 20);
      expect_frame(md_q, pl_q);
      send_frame(7, md_q, pl_q);
      check_step("t6_pair", 0);

      fill(md_q, 8'he0, 8);
      sb.push_back({2'b01, 4'h0, 8'he0, 8'he1, 8'he2, 8'he3, 8'he4, 8'he5, 8'he6, 8'he7, 64'd0});
      drive(8'h55);
      drive(8'hd5);
      foreach (md_q[k]) drive(md_q[k]);
      for (int k = 0; k < 10; k++) drive(8'h80 + 8'(k));
      @(negedge clk);
      rst_n = 1'b0;
      wr    = 1'b0;
      #2;
      chk(ov_pkt_data, 134'd0, "mid_rst_data");
      chk({133'd0, o_pkt_data_wr}, 134'd0, "mid_rst_wr");
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      check_step("t6_rst", 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
